// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, stall/flush handling
// and a saturating count of inserted bubbles.
module id_ex_pipe #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int CTRL_W  = 12,
   parameter int STALL_W = 6,
   parameter int STAGE   = 2,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_rs1_data,
   input  logic [DATA_W-1:0]  in_rs2_data,
   input  logic [DATA_W-1:0]  in_imm,
   input  logic               in_rs1_rd_en,
   input  logic               in_rs2_rd_en,
   input  logic [ADDR_W-1:0]  in_rs1_addr,
   input  logic [ADDR_W-1:0]  in_rs2_addr,
   input  logic [ADDR_W-1:0]  in_rd_addr,
   input  logic               in_mem_read,
   input  logic               in_reg_write,
   input  logic [CTRL_W-1:0]  in_ctrl,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_rs1_data,
   output logic [DATA_W-1:0]  out_rs2_data,
   output logic [DATA_W-1:0]  out_imm,
   output logic               out_rs1_rd_en,
   output logic               out_rs2_rd_en,
   output logic [ADDR_W-1:0]  out_rs1_addr,
   output logic [ADDR_W-1:0]  out_rs2_addr,
   output logic [ADDR_W-1:0]  out_rd_addr,
   output logic               out_mem_read,
   output logic               out_reg_write,
   output logic [CTRL_W-1:0]  out_ctrl,
   output logic               load_use_stall,
   output logic [CNT_W-1:0]   bubble_cnt
);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] rs1_data;
      logic [DATA_W-1:0] rs2_data;
      logic [DATA_W-1:0] imm;
      logic              rs1_rd_en;
      logic              rs2_rd_en;
      logic [ADDR_W-1:0] rs1_addr;
      logic [ADDR_W-1:0] rs2_addr;
      logic [ADDR_W-1:0] rd_addr;
      logic              mem_read;
      logic              reg_write;
      logic [CTRL_W-1:0] ctrl;
   } entry_t;

   entry_t           in_e;
   entry_t           ent_d, ent_q;
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic             hold;
   logic             upstream_stall;
   logic             hazard_raw;
   logic             lus;
   logic             take_bubble;

   assign in_e = '{
      valid:     in_valid,
      rs1_data:  in_rs1_data,
      rs2_data:  in_rs2_data,
      imm:       in_imm,
      rs1_rd_en: in_rs1_rd_en,
      rs2_rd_en: in_rs2_rd_en,
      rs1_addr:  in_rs1_addr,
      rs2_addr:  in_rs2_addr,
      rd_addr:   in_rd_addr,
      mem_read:  in_mem_read,
      reg_write: in_reg_write,
      ctrl:      in_ctrl
   };

   assign hold           = stall[STAGE];
   assign upstream_stall = stall[STAGE-1];

   // A load sitting in EX whose destination is read by the ID entry needs one bubble.
   always_comb begin
      hazard_raw = in_valid & ent_q.valid & ent_q.mem_read & (ent_q.rd_addr != '0) &
                   ((in_rs1_rd_en & (in_rs1_addr == ent_q.rd_addr)) |
                    (in_rs2_rd_en & (in_rs2_addr == ent_q.rd_addr)));
      lus = hazard_raw & ~flush & ~hold & ~rst;
   end

   assign load_use_stall = lus;

   always_comb begin
      ent_d        = ent_q;
      bubble_cnt_d = bubble_cnt_q;
      take_bubble  = 1'b0;
      if (flush) begin
         take_bubble = 1'b1;
      end else if (hold) begin
         take_bubble = 1'b0;
      end else if (upstream_stall | lus) begin
         take_bubble = 1'b1;
      end else begin
         ent_d = in_e;
      end
      if (take_bubble) begin
         ent_d = '0;
         if (bubble_cnt_q != {CNT_W{1'b1}})
            bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_q        <= '0;
         bubble_cnt_q <= '0;
      end else begin
         ent_q        <= ent_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign out_valid     = ent_q.valid;
   assign out_rs1_data  = ent_q.rs1_data;
   assign out_rs2_data  = ent_q.rs2_data;
   assign out_imm       = ent_q.imm;
   assign out_rs1_rd_en = ent_q.rs1_rd_en;
   assign out_rs2_rd_en = ent_q.rs2_rd_en;
   assign out_rs1_addr  = ent_q.rs1_addr;
   assign out_rs2_addr  = ent_q.rs2_addr;
   assign out_rd_addr   = ent_q.rd_addr;
   assign out_mem_read  = ent_q.mem_read;
   assign out_reg_write = ent_q.reg_write;
   assign out_ctrl      = ent_q.ctrl;
   assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed-vector bench for id_ex_pipe: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_id_ex_pipe;

   typedef struct packed {
      logic        valid;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic        rs1_rd_en;
      logic        rs2_rd_en;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic        mem_read;
      logic        reg_write;
      logic [11:0] ctrl;
   } ent_t;

   typedef struct {
      string nm;
      ent_t  st;
      int    cnt;
      bit    lus;
      int    sat;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst_s = 1'b1;
   logic       flush = 1'b0;
   logic       flush_s = 1'b0;
   logic [5:0] stall = '0;
   ent_t       din = '0;

   ent_t        dout;
   logic        o_valid, o_r1en, o_r2en, o_mr, o_rw, o_lus;
   logic [31:0] o_r1d, o_r2d, o_imm;
   logic [4:0]  o_a1, o_a2, o_rd;
   logic [11:0] o_ctrl;
   logic [15:0] o_cnt;

   logic        s_valid, s_r1en, s_r2en, s_mr, s_rw, s_lus;
   logic [31:0] s_r1d, s_r2d, s_imm;
   logic [4:0]  s_a1, s_a2, s_rd;
   logic [11:0] s_ctrl;
   logic [1:0]  s_cnt;

   rec_t exp_q[$];
   int   n_total = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   id_ex_pipe u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(din.valid), .in_rs1_data(din.rs1_data), .in_rs2_data(din.rs2_data),
      .in_imm(din.imm), .in_rs1_rd_en(din.rs1_rd_en), .in_rs2_rd_en(din.rs2_rd_en),
      .in_rs1_addr(din.rs1_addr), .in_rs2_addr(din.rs2_addr), .in_rd_addr(din.rd_addr),
      .in_mem_read(din.mem_read), .in_reg_write(din.reg_write), .in_ctrl(din.ctrl),
      .out_valid(o_valid), .out_rs1_data(o_r1d), .out_rs2_data(o_r2d), .out_imm(o_imm),
      .out_rs1_rd_en(o_r1en), .out_rs2_rd_en(o_r2en), .out_rs1_addr(o_a1),
      .out_rs2_addr(o_a2), .out_rd_addr(o_rd), .out_mem_read(o_mr),
      .out_reg_write(o_rw), .out_ctrl(o_ctrl), .load_use_stall(o_lus), .bubble_cnt(o_cnt)
   );

   id_ex_pipe #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst_s), .stall(stall), .flush(flush_s),
      .in_valid(din.valid), .in_rs1_data(din.rs1_data), .in_rs2_data(din.rs2_data),
      .in_imm(din.imm), .in_rs1_rd_en(din.rs1_rd_en), .in_rs2_rd_en(din.rs2_rd_en),
      .in_rs1_addr(din.rs1_addr), .in_rs2_addr(din.rs2_addr), .in_rd_addr(din.rd_addr),
      .in_mem_read(din.mem_read), .in_reg_write(din.reg_write), .in_ctrl(din.ctrl),
      .out_valid(s_valid), .out_rs1_data(s_r1d), .out_rs2_data(s_r2d), .out_imm(s_imm),
      .out_rs1_rd_en(s_r1en), .out_rs2_rd_en(s_r2en), .out_rs1_addr(s_a1),
      .out_rs2_addr(s_a2), .out_rd_addr(s_rd), .out_mem_read(s_mr),
      .out_reg_write(s_rw), .out_ctrl(s_ctrl), .load_use_stall(s_lus), .bubble_cnt(s_cnt)
   );

   assign dout = '{valid: o_valid, rs1_data: o_r1d, rs2_data: o_r2d, imm: o_imm,
                   rs1_rd_en: o_r1en, rs2_rd_en: o_r2en, rs1_addr: o_a1, rs2_addr: o_a2,
                   rd_addr: o_rd, mem_read: o_mr, reg_write: o_rw, ctrl: o_ctrl};

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   // Monitor: the DUT presents a registered entry every cycle; compare mid-cycle.
   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk({r.nm, "/state"}, 256'(dout), 256'(r.st));
            chk({r.nm, "/cnt"}, 256'(o_cnt), 256'(r.cnt));
            chk({r.nm, "/lus"}, 256'(o_lus), 256'(r.lus));
            if (r.sat >= 0) chk({r.nm, "/sat_cnt"}, 256'(s_cnt), 256'(r.sat));
         end
      end
   end

   function automatic ent_t mk(input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] im, input logic e1, input logic e2,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] rd, input logic mr, input logic rw,
                               input logic [11:0] c);
      ent_t e;
      e = '{valid: 1'b1, rs1_data: d1, rs2_data: d2, imm: im, rs1_rd_en: e1,
            rs2_rd_en: e2, rs1_addr: a1, rs2_addr: a2, rd_addr: rd, mem_read: mr,
            reg_write: rw, ctrl: c};
      return e;
   endfunction

   // Drive one cycle of stimulus just after the edge and queue what the monitor
   // must see before the next edge: es/ec are the result of the edge just taken.
   task automatic step(input string nm, input ent_t d, input ent_t es, input int ec,
                       input bit el, input logic [5:0] st = '0, input bit fl = 1'b0,
                       input bit r = 1'b0, input int sat = -1, input bit rs = 1'b1,
                       input bit fs = 1'b0);
      rec_t rc;
      @(posedge clk);
      #1;
      rst = r; rst_s = rs; flush = fl; flush_s = fs; stall = st; din = d;
      rc.nm = nm; rc.st = es; rc.cnt = ec; rc.lus = el; rc.sat = sat;
      exp_q.push_back(rc);
   endtask

   initial begin
      ent_t BUB, A, L, U, L0, Z, L2, U2, L3, X, Y, YN;
      BUB = '0;
      A  = mk(32'h1234_5678, 32'h0BAD_F00D, 32'h10, 1, 1, 5'd1, 5'd2, 5'd5, 0, 1, 12'hA5A);
      L  = mk(32'h11, 32'h22, 32'h4, 1, 0, 5'd3, 5'd0, 5'd7, 1, 1, 12'h123);
      U  = mk(32'h33, 32'h44, 32'h8, 1, 1, 5'd4, 5'd7, 5'd9, 0, 1, 12'h0F0);
      L0 = mk(32'h55, 32'h66, 32'h0, 1, 0, 5'd8, 5'd0, 5'd0, 1, 0, 12'h800);
      Z  = mk(32'h77, 32'h88, 32'h1, 1, 0, 5'd0, 5'd0, 5'd4, 0, 1, 12'h001);
      L2 = mk(32'h99, 32'hAA, 32'h2, 1, 0, 5'd10, 5'd0, 5'd12, 1, 1, 12'h321);
      U2 = mk(32'hBB, 32'hCC, 32'h3, 1, 1, 5'd12, 5'd11, 5'd13, 0, 1, 12'h456);
      L3 = mk(32'hDD, 32'hEE, 32'h5, 0, 0, 5'd0, 5'd0, 5'd19, 1, 1, 12'h789);
      X  = mk(32'h1010, 32'h2020, 32'h6, 1, 0, 5'd3, 5'd19, 5'd14, 0, 1, 12'hABC);
      Y  = mk(32'h3030, 32'h4040, 32'h7, 1, 0, 5'd19, 5'd0, 5'd15, 0, 1, 12'hDEF);
      YN = Y; YN.valid = 1'b0;

      step("in_reset",    A,  BUB, 0, 0, .r(1'b1));
      step("reset_rel",   A,  BUB, 0, 0);
      step("load_A",      L,  A,   0, 0);
      step("lu_detect",   U,  L,   0, 1);
      step("lu_bubble",   U,  BUB, 1, 0);
      step("lu_release",  L0, U,   1, 0);
      step("zero_reg",    Z,  L0,  1, 0);
      step("zero_load",   L2, Z,   1, 0);
      step("lu2_detect",  U2, L2,  1, 1);
      step("lu2_bubble",  U2, BUB, 2, 0);
      step("lu2_release", L3, U2,  2, 0);
      step("addr_msb",    X,  L3,  2, 0);
      step("load_X",      L3, X,   2, 0);
      step("inval_ustall", YN, L3, 2, 0, .st(6'b000010));
      step("ustall_bub",  L3, BUB, 3, 0);
      step("hold_1",      Y,  L3,  3, 0, .st(6'b000100));
      step("hold_2",      Y,  L3,  3, 0, .st(6'b000100));
      step("hold_3",      Y,  L3,  3, 0, .st(6'b000100));
      step("hold_flush",  Y,  L3,  3, 0, .st(6'b000100), .fl(1'b1));
      step("flush_bub",   A,  BUB, 4, 0);
      step("reload_A",    L,  A,   4, 0);
      step("flush_haz",   U,  L,   4, 0, .fl(1'b1));
      step("flush_bub2",  U,  BUB, 5, 0);
      step("load_U",      A,  U,   5, 0);
      step("async_rst",   A,  BUB, 0, 0, .r(1'b1));
      step("rst_held",    A,  BUB, 0, 0, .r(1'b1));
      step("post_rst",    L,  BUB, 0, 0);
      step("post_rst_ld", Z,  L,   0, 0);

      step("sat_0", BUB, BUB, 0, 0, .r(1'b1), .rs(1'b0), .fs(1'b1), .sat(0));
      step("sat_1", BUB, BUB, 0, 0, .r(1'b1), .rs(1'b0), .fs(1'b1), .sat(1));
      step("sat_2", BUB, BUB, 0, 0, .r(1'b1), .rs(1'b0), .fs(1'b1), .sat(2));
      step("sat_3", BUB, BUB, 0, 0, .r(1'b1), .rs(1'b0), .fs(1'b1), .sat(3));
      step("sat_4", BUB, BUB, 0, 0, .r(1'b1), .rs(1'b0), .fs(1'b1), .sat(3));
      step("sat_5", BUB, BUB, 0, 0, .r(1'b1), .rs(1'b0), .fs(1'b0), .sat(3));

      repeat (3) @(negedge clk);
      chk("drain", 256'(exp_q.size()), 256'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 32, register/immediate data width.
REQ-002 ADDR_W, 5, register address width; CTRL_W, 12, opaque EX/MEM/WB control bundle width.
REQ-003 STALL_W, 6, stall vector width; STAGE, 2, index of this stage in the stall vector (1..STALL_W-1); CNT_W, 16, bubble counter width.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be (name direction width meaning): clk in 1 clock; rst in 1 async active-high reset.
REQ-006 stall in STALL_W per-stage stall vector; flush in 1 kill incoming and held entry (branch taken).
REQ-007 in_valid in 1 ID entry valid; in_rs1_data, in_rs2_data, in_imm in DATA_W each, operands and immediate.
REQ-008 in_rs1_rd_en, in_rs2_rd_en in 1 each; in_rs1_addr, in_rs2_addr, in_rd_addr in ADDR_W each.
REQ-009 in_mem_read in 1 load; in_reg_write in 1 writeback; in_ctrl in CTRL_W remaining control bits.
REQ-010 out_valid out 1, plus out_* counterparts of every in_* field, same widths, registered.
REQ-011 load_use_stall out 1 combinational hazard request; bubble_cnt out CNT_W saturating bubble count.

Function
REQ-012 Update priority per rising clk SHALL be: flush > hold > bubble > load.
REQ-013 flush=1: register SHALL load a bubble regardless of stall or hazard.
REQ-014 hold (stall[STAGE]=1, flush=0): all out_* and out_valid SHALL retain value; bubble_cnt unchanged.
REQ-015 bubble (flush=0, stall[STAGE]=0, and stall[STAGE-1]=1 or load_use_stall=1): register SHALL load a bubble.
REQ-016 load (none of the above): every out_* SHALL take its in_* value next cycle; out_valid=in_valid.
REQ-017 Bubble SHALL mean: out_valid=0, out_mem_read=0, out_reg_write=0, out_ctrl=0, all addresses, rd_en bits and data fields 0.
REQ-018 load_use_stall SHALL be 1 iff in_valid & out_valid & out_mem_read & (out_rd_addr!=0) & ((in_rs1_rd_en & in_rs1_addr==out_rd_addr) | (in_rs2_rd_en & in_rs2_addr==out_rd_addr)).
REQ-019 load_use_stall SHALL be forced 0 while flush=1 or stall[STAGE]=1.
REQ-020 Upstream stall/PC logic consumes load_use_stall; this block SHALL not modify the stall input.
REQ-021 Latency ID->EX SHALL be exactly one cycle on a load; a hazard SHALL cost exactly one bubble per load-use pair.
REQ-022 Back-to-back hazards: after a bubble, out_valid=0 so load_use_stall SHALL drop and the held ID entry loads next cycle.
REQ-023 bubble_cnt SHALL increment by 1 on every bubble load (flush or REQ-015) and saturate at 2^CNT_W-1 without wrap.
REQ-024 Address compare SHALL use full ADDR_W bits; register 0 SHALL never produce a hazard.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) clear all out_* to 0, out_valid=0, bubble_cnt=0.
REQ-026 While rst=1, load_use_stall SHALL be 0; first load occurs on the first rising clk after rst deasserts.
REQ-027 rst asserted mid-hold or mid-hazard SHALL discard the entry; no state survives reset.

Verification
REQ-028 Load: in_valid=1, rs1_data=0x1234_5678, rd=5, ctrl=0xA5A, stall=0 -> next cycle out_valid=1, out_rs1_data=0x12345678, out_rd_addr=5, out_ctrl=0xA5A.
REQ-029 Load-use: out holds load rd=7 (mem_read=1), in rs2_addr=7 rs2_rd_en=1 -> load_use_stall=1; next cycle bubble, bubble_cnt=1; with in held, following cycle loads it, load_use_stall=0.
REQ-030 Zero reg: out load rd=0, in rs1_addr=0 rs1_rd_en=1 -> load_use_stall=0, entry loads directly.
REQ-031 Hold vs flush: stall=6'b000100 for 3 cycles -> outputs frozen, cnt unchanged; then stall and flush both 1 -> bubble, cnt+1.
REQ-032 Saturation: CNT_W=2, 5 consecutive flushes -> bubble_cnt 1,2,3,3,3.
REQ-033 Async reset: assert rst between clk edges with out_valid=1 -> out_valid=0, bubble_cnt=0 before next edge.
